// File: rtl/pid_pkg.sv
// Shared types, width helpers and the symmetric saturate function for the multichannel PID.
package pid_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ERR  = 3'd1,
        MUL  = 3'd2,
        SUM  = 3'd3,
        WR   = 3'd4,
        DONE = 3'd5
    } pid_state_e;

    localparam int SAT_MAX_W = 64;

    function automatic int err_w(input int w);
        return w + 32'sd1;
    endfunction

    function automatic int prod_w(input int w);
        return 32'sd2 * w + 32'sd2;
    endfunction

    function automatic int acc_w(input int w);
        return 32'sd2 * w + 32'sd4;
    endfunction

    // A negative limit collapses to zero so the result is forced to 0.
    function automatic logic signed [SAT_MAX_W-1:0] sat(
        input logic signed [SAT_MAX_W-1:0] x,
        input logic signed [SAT_MAX_W-1:0] lim
    );
        logic signed [SAT_MAX_W-1:0] mag;
        mag = lim[SAT_MAX_W-1] ? {SAT_MAX_W{1'b0}} : lim;
        if (x > mag) begin
            sat = mag;
        end else if (x < -mag) begin
            sat = -mag;
        end else begin
            sat = x;
        end
    endfunction

endpackage

// File: rtl/pid_multichannel_if.sv
// Sweep handshake between the motor-board sequencer and the multichannel PID.
interface pid_multichannel_if;
    logic update;
    logic busy;
    logic done;

    modport master (output update, input busy, input done);
    modport slave  (input update, output busy, output done);
endinterface

// File: rtl/pid_sat.sv
// Combinational symmetric saturator: clamps a wide signed value to +/-lim.
module pid_sat
    import pid_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 8
) (
    input  logic signed [IN_W-1:0]  x,
    input  logic signed [OUT_W-1:0] lim,
    output logic signed [OUT_W-1:0] y
);
    logic signed [SAT_MAX_W-1:0] x_ext_s;
    logic signed [SAT_MAX_W-1:0] lim_ext_s;

    assign x_ext_s   = {{(SAT_MAX_W-IN_W){x[IN_W-1]}}, x};
    assign lim_ext_s = {{(SAT_MAX_W-OUT_W){lim[OUT_W-1]}}, lim};
    assign y         = OUT_W'(sat(x_ext_s, lim_ext_s));
endmodule

// File: rtl/pid_multichannel.sv
// Time-multiplexed PID over N_CH channels sharing one multiplier datapath.
// Optional feature macro: PID_DEADBAND_EN (zeroes outputs whose magnitude is within deadband).
module pid_multichannel
    import pid_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int W      = 24,
    parameter int FRAC   = 8,
    parameter int KD_DIV = 128
) (
    input  logic               CLK,
    input  logic               reset,
    pid_multichannel_if.slave  bus,
    input  logic [N_CH*W-1:0]  setpoint,
    input  logic [N_CH*W-1:0]  state,
    input  logic [N_CH*W-1:0]  Kp,
    input  logic [N_CH*W-1:0]  Ki,
    input  logic [N_CH*W-1:0]  Kd,
    input  logic [N_CH*W-1:0]  PWMLimit,
    input  logic [N_CH*W-1:0]  IntegralLimit,
    input  logic [N_CH*W-1:0]  deadband,
    output logic [N_CH*W-1:0]  duty
);
    localparam int ERR_W  = err_w(W);
    localparam int PROD_W = prod_w(W);
    localparam int ACC_W  = acc_w(W);
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W  = (KD_DIV > 1) ? $clog2(KD_DIV) : 1;
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);
    localparam logic [CH_W-1:0]  CH_ONE   = CH_W'(1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    pid_state_e state_r, state_s;
    logic busy_r, busy_s, done_r, done_s;
    logic [CH_W-1:0]  ch_r;
    logic [CNT_W-1:0] cnt_r;
    logic signed [ERR_W-1:0]  err_r;
    logic signed [PROD_W-1:0] p_p_r, p_i_r, p_d_r;
    logic signed [W-1:0]      res_r;
    logic signed [W-1:0]      integral_r [N_CH];
    logic signed [ERR_W-1:0]  err_prev_r [N_CH];
    logic signed [W-1:0]      duty_r     [N_CH];

    logic signed [W-1:0] sp_a [N_CH], st_a [N_CH], kp_a [N_CH], ki_a [N_CH], kd_a [N_CH];
    logic signed [W-1:0] plim_a [N_CH], ilim_a [N_CH];

    logic signed [ERR_W-1:0]  err_s;
    logic signed [W+1:0]      int_sum_s, diff_s;
    logic signed [W-1:0]      int_sat_s, res_sat_s, res_s;
    logic signed [PROD_W-1:0] p_p_s, p_i_s, p_d_s;
    logic signed [ACC_W-1:0]  acc_s, scaled_s;

    for (genvar g = 0; g < N_CH; g++) begin : g_unpack
        assign sp_a[g]   = setpoint[g*W +: W];
        assign st_a[g]   = state[g*W +: W];
        assign kp_a[g]   = Kp[g*W +: W];
        assign ki_a[g]   = Ki[g*W +: W];
        assign kd_a[g]   = Kd[g*W +: W];
        assign plim_a[g] = PWMLimit[g*W +: W];
        assign ilim_a[g] = IntegralLimit[g*W +: W];
        assign duty[g*W +: W] = duty_r[g];
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;

    // Shared datapath: error, integrator sum, products and scaled sum, all sized to avoid wrap.
    always_comb begin
        err_s     = ERR_W'(sp_a[ch_r]) - ERR_W'(st_a[ch_r]);
        int_sum_s = (W+2)'(integral_r[ch_r]) + (W+2)'(err_s);
        diff_s    = (W+2)'(err_r) - (W+2)'(err_prev_r[ch_r]);
        p_p_s     = PROD_W'(kp_a[ch_r]) * PROD_W'(err_r);
        p_i_s     = PROD_W'(ki_a[ch_r]) * PROD_W'(integral_r[ch_r]);
        p_d_s     = PROD_W'(kd_a[ch_r]) * PROD_W'(diff_s);
        acc_s     = ACC_W'(p_p_r) + ACC_W'(p_i_r) + ACC_W'(p_d_r);
        scaled_s  = acc_s >>> FRAC;
    end

    pid_sat #(.IN_W(W+2), .OUT_W(W)) u_int_sat (
        .x   (int_sum_s),
        .lim (ilim_a[ch_r]),
        .y   (int_sat_s)
    );

    pid_sat #(.IN_W(ACC_W), .OUT_W(W)) u_out_sat (
        .x   (scaled_s),
        .lim (plim_a[ch_r]),
        .y   (res_sat_s)
    );

`ifdef PID_DEADBAND_EN
    logic signed [W-1:0] db_a [N_CH];
    logic signed [W-1:0] res_abs_s;

    for (genvar g = 0; g < N_CH; g++) begin : g_db
        assign db_a[g] = deadband[g*W +: W];
    end

    // Deadband: small saturated outputs are suppressed, the integrator is unaffected.
    always_comb begin
        res_abs_s = res_sat_s[W-1] ? -res_sat_s : res_sat_s;
        if (res_abs_s <= db_a[ch_r]) begin
            res_s = {W{1'b0}};
        end else begin
            res_s = res_sat_s;
        end
    end
`else
    logic unused_deadband_s;
    assign unused_deadband_s = ^deadband;
    assign res_s = res_sat_s;
`endif

    // FSM state and registered handshake outputs.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // FSM next state; update is only honoured from IDLE so sweeps never queue.
    always_comb begin
        state_s = state_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.update) begin
                    state_s = ERR;
                    busy_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            ERR: state_s = MUL;
            MUL: state_s = SUM;
            SUM: state_s = WR;
            WR: begin
                if (ch_r == LAST_CH) begin
                    state_s = DONE;
                end else begin
                    state_s = ERR;
                end
            end
            DONE: begin
                state_s = IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b1;
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Per-stage datapath registers and per-channel integrator/derivative history.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            ch_r  <= {CH_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
            err_r <= {ERR_W{1'b0}};
            p_p_r <= {PROD_W{1'b0}};
            p_i_r <= {PROD_W{1'b0}};
            p_d_r <= {PROD_W{1'b0}};
            res_r <= {W{1'b0}};
            for (int i = 0; i < N_CH; i++) begin
                integral_r[i] <= {W{1'b0}};
                err_prev_r[i] <= {ERR_W{1'b0}};
                duty_r[i]     <= {W{1'b0}};
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.update) begin
                        ch_r <= {CH_W{1'b0}};
                    end
                end
                ERR: begin
                    err_r            <= err_s;
                    integral_r[ch_r] <= int_sat_s;
                end
                MUL: begin
                    p_p_r <= p_p_s;
                    p_i_r <= p_i_s;
                    p_d_r <= p_d_s;
                end
                SUM: res_r <= res_s;
                WR: begin
                    duty_r[ch_r] <= res_r;
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        err_prev_r[ch_r] <= err_r;
                    end
                    if (ch_r != LAST_CH) begin
                        ch_r <= ch_r + CH_ONE;
                    end
                end
                DONE: begin
                    cnt_r <= (cnt_r == LAST_CNT) ? {CNT_W{1'b0}} : cnt_r + CNT_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule
